// File: rtl/slavefifo2b_bus_arbiter.sv
// Round-robin arbiter sharing one FX3 slave-FIFO port between three requesters,
// with address setup and bus turnaround phases. Optional watchdog: SLAVEFIFO_ARB_WATCHDOG_EN.
module slavefifo2b_bus_arbiter #(
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned MAX_HOLD    = 4096
) (
    input  logic        clk_100,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  done,
    input  logic [2:0]  slrd_req_n,
    input  logic [2:0]  sloe_req_n,
    input  logic [2:0]  slwr_req_n,
    input  logic [2:0]  pktend_req_n,
    input  logic [5:0]  addr_req,
    input  logic [95:0] wdata_req,
    output logic [2:0]  gnt,
    output logic        slrd_,
    output logic        sloe_,
    output logic        slwr_,
    output logic        pktend_,
    output logic [1:0]  faddr,
    output logic [31:0] fdata_out,
    output logic        fdata_oe,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_OWN, ST_TURN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_owner_q, last_owner_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [2:0]  turn_cnt_q, turn_cnt_d;
    logic [1:0]  faddr_q, faddr_d;
    logic        timeout_q, timeout_d;
    logic        wd_fire_s;
    logic        release_s;
    logic [1:0]  winner_s;

    // Search order starts at the requester after the previous owner.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] c0, c1, c2;
        case (last)
            2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
            2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
            default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
        endcase
        if (r[c0]) begin
            rr_pick = c0;
        end else if (r[c1]) begin
            rr_pick = c1;
        end else begin
            rr_pick = c2;
        end
    endfunction

    assign winner_s = rr_pick(req, last_owner_q);

`ifdef SLAVEFIFO_ARB_WATCHDOG_EN
    logic [15:0] hold_q, hold_d;

    // Hold counter: cleared in SETUP so it reads zero on the first OWN cycle.
    always_comb begin
        hold_d = hold_q;
        case (state_q)
            ST_SETUP: hold_d = 16'd0;
            ST_OWN:   hold_d = hold_q + 16'd1;
            default:  hold_d = hold_q;
        endcase
    end

    // Hold counter register.
    always_ff @(posedge clk_100) begin
        if (reset) begin
            hold_q <= 16'd0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign wd_fire_s = (state_q == ST_OWN) && (hold_q == 16'(MAX_HOLD - 1));
`else
    logic unused_max_hold_s;
    assign unused_max_hold_s = ^(16'(MAX_HOLD));
    assign wd_fire_s = 1'b0;
`endif

    assign release_s = done[owner_q] | ~req[owner_q] | wd_fire_s;

    // Next-state and grant bookkeeping.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        gnt_d        = gnt_q;
        turn_cnt_d   = turn_cnt_q;
        timeout_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_SETUP;
                    owner_d = winner_s;
                    gnt_d   = 3'b001 << winner_s;
                end else begin
                    gnt_d   = 3'b000;
                end
            end
            ST_SETUP: state_d = ST_OWN;
            ST_OWN: begin
                if (release_s) begin
                    state_d      = ST_TURN;
                    gnt_d        = 3'b000;
                    last_owner_d = owner_q;
                    turn_cnt_d   = 3'd0;
                    timeout_d    = wd_fire_s;
                end else begin
                    state_d      = ST_OWN;
                end
            end
            ST_TURN: begin
                if (turn_cnt_q == 3'(TURN_CYCLES - 1)) begin
                    state_d    = ST_IDLE;
                    turn_cnt_d = 3'd0;
                end else begin
                    turn_cnt_d = turn_cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    // Bus-side outputs: only OWN passes the owner's strobes through.
    always_comb begin
        slrd_     = 1'b1;
        sloe_     = 1'b1;
        slwr_     = 1'b1;
        pktend_   = 1'b1;
        fdata_out = 32'd0;
        fdata_oe  = 1'b0;
        faddr     = faddr_q;
        case (state_q)
            ST_SETUP: faddr = addr_req[{owner_q, 1'b0} +: 2];
            ST_OWN: begin
                slrd_     = slrd_req_n[owner_q];
                sloe_     = sloe_req_n[owner_q];
                slwr_     = slwr_req_n[owner_q];
                pktend_   = pktend_req_n[owner_q];
                faddr     = addr_req[{owner_q, 1'b0} +: 2];
                fdata_out = wdata_req[{owner_q, 5'b00000} +: 32];
                fdata_oe  = ~slwr_req_n[owner_q];
            end
            default: faddr = faddr_q;
        endcase
        faddr_d = faddr;
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk_100) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 2'd0;
            last_owner_q <= 2'd2;
            gnt_q        <= 3'b000;
            turn_cnt_q   <= 3'd0;
            faddr_q      <= 2'd0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            gnt_q        <= gnt_d;
            turn_cnt_q   <= turn_cnt_d;
            faddr_q      <= faddr_d;
            timeout_q    <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q != ST_IDLE);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_slavefifo2b_bus_arbiter.sv
// Directed bench for slavefifo2b_bus_arbiter: grant, contention, turnaround,
// reset, non-owner done and watchdog scenarios with hand-computed expectations.
module tb_slavefifo2b_bus_arbiter;

    logic        clk_100 = 1'b0;
    logic        reset;
    logic [2:0]  req, done, slrd_req_n, sloe_req_n, slwr_req_n, pktend_req_n;
    logic [5:0]  addr_req;
    logic [95:0] wdata_req;
    logic [2:0]  gnt;
    logic        slrd_, sloe_, slwr_, pktend_;
    logic [1:0]  faddr;
    logic [31:0] fdata_out;
    logic        fdata_oe, busy, timeout;

    int tests_run = 0;
    int fails     = 0;

    slavefifo2b_bus_arbiter #(.TURN_CYCLES(2), .MAX_HOLD(16)) dut (
        .clk_100(clk_100), .reset(reset), .req(req), .done(done),
        .slrd_req_n(slrd_req_n), .sloe_req_n(sloe_req_n), .slwr_req_n(slwr_req_n),
        .pktend_req_n(pktend_req_n), .addr_req(addr_req), .wdata_req(wdata_req),
        .gnt(gnt), .slrd_(slrd_), .sloe_(sloe_), .slwr_(slwr_), .pktend_(pktend_),
        .faddr(faddr), .fdata_out(fdata_out), .fdata_oe(fdata_oe), .busy(busy),
        .timeout(timeout)
    );

    always #5 clk_100 = ~clk_100;

    always @(negedge clk_100) begin
        if (!reset) begin
            tests_run++;
            if (!$onehot0(gnt)) begin
                fails++;
                $display("FAIL gnt_onehot: gnt=%b required one-hot or zero", gnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk_100);
        #2;
    endtask

    task automatic idle_inputs();
        req = 3'b000; done = 3'b000;
        slrd_req_n = 3'b111; sloe_req_n = 3'b111; slwr_req_n = 3'b111; pktend_req_n = 3'b111;
        addr_req = {2'b11, 2'b10, 2'b01};
        wdata_req = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({gnt, slrd_, sloe_, slwr_, pktend_, faddr, fdata_oe, busy, timeout} !== {3'b000, 4'b1111, 2'b00, 3'b000}) begin
            fails++;
            $display("FAIL reset_outputs: gnt=%b strobes=%b%b%b%b faddr=%b oe=%b busy=%b to=%b required 000 1111 00 0 0 0",
                     gnt, slrd_, sloe_, slwr_, pktend_, faddr, fdata_oe, busy, timeout);
        end
        tests_run++;
        if (fdata_out !== 32'd0) begin
            fails++;
            $display("FAIL reset_fdata: got %h required 0", fdata_out);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 3'b001; slrd_req_n = 3'b110;
        tick();
        tests_run++;
        if ({gnt, slrd_, faddr, busy} !== {3'b001, 1'b1, 2'b01, 1'b1}) begin
            fails++;
            $display("FAIL single_setup: gnt=%b slrd=%b faddr=%b busy=%b required 001 1 01 1", gnt, slrd_, faddr, busy);
        end
        tick();
        tests_run++;
        if (slrd_ !== 1'b0) begin
            fails++;
            $display("FAIL single_own_slrd: got %b required 0", slrd_);
        end
        slrd_req_n = 3'b111;
        #1;
        tests_run++;
        if (slrd_ !== 1'b1) begin
            fails++;
            $display("FAIL single_follow: got %b required 1", slrd_);
        end
        done = 3'b001;
        tick();
        done = 3'b000; req = 3'b000;
        tests_run++;
        if ({gnt, busy} !== {3'b000, 1'b1}) begin
            fails++;
            $display("FAIL single_release: gnt=%b busy=%b required 000 1", gnt, busy);
        end
        tick();
        tests_run++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL single_turn2_busy: got %b required 1", busy);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL single_idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_contention();
        logic [2:0] exp_order [4];
        exp_order[0] = 3'b001; exp_order[1] = 3'b010; exp_order[2] = 3'b100; exp_order[3] = 3'b001;
        do_reset();
        req = 3'b111; slrd_req_n = 3'b000;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if ({gnt, slrd_} !== {exp_order[k], 1'b1}) begin
                fails++;
                $display("FAIL contention_grant%0d: gnt=%b slrd=%b required %b 1", k, gnt, slrd_, exp_order[k]);
            end
            tick();
            tests_run++;
            if (slrd_ !== 1'b0) begin
                fails++;
                $display("FAIL contention_live%0d: slrd=%b required 0", k, slrd_);
            end
            repeat (4) tick();
            done = exp_order[k];
            tick();
            done = 3'b000;
            tests_run++;
            if ({gnt, slrd_} !== {3'b000, 1'b1}) begin
                fails++;
                $display("FAIL contention_turn1_%0d: gnt=%b slrd=%b required 000 1", k, gnt, slrd_);
            end
            tick();
            tests_run++;
            if ({gnt, slrd_, fdata_oe} !== {3'b000, 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL contention_turn2_%0d: gnt=%b slrd=%b oe=%b required 000 1 0", k, gnt, slrd_, fdata_oe);
            end
            tick();
        end
        req = 3'b000; slrd_req_n = 3'b111;
    endtask

    task automatic test_turnaround();
        do_reset();
        req = 3'b010; slwr_req_n = 3'b101;
        wdata_req = {32'h0, 32'hDEADBEEF, 32'h0};
        tick();
        tests_run++;
        if ({slwr_, fdata_oe, fdata_out} !== {1'b1, 1'b0, 32'd0}) begin
            fails++;
            $display("FAIL turn_setup: slwr=%b oe=%b data=%h required 1 0 0", slwr_, fdata_oe, fdata_out);
        end
        tick();
        tests_run++;
        if ({gnt, slwr_, fdata_oe, fdata_out, faddr} !== {3'b010, 1'b0, 1'b1, 32'hDEADBEEF, 2'b10}) begin
            fails++;
            $display("FAIL turn_own: gnt=%b slwr=%b oe=%b data=%h faddr=%b required 010 0 1 deadbeef 10",
                     gnt, slwr_, fdata_oe, fdata_out, faddr);
        end
        done = 3'b010;
        tick();
        done = 3'b000; req = 3'b000;
        for (int t = 0; t < 2; t++) begin
            tests_run++;
            if ({slwr_, fdata_oe, fdata_out, faddr} !== {1'b1, 1'b0, 32'd0, 2'b10}) begin
                fails++;
                $display("FAIL turn_cycle%0d: slwr=%b oe=%b data=%h faddr=%b required 1 0 0 10",
                         t, slwr_, fdata_oe, fdata_out, faddr);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 3'b001; slrd_req_n = 3'b110; sloe_req_n = 3'b110;
        tick();
        tick();
        tests_run++;
        if (slrd_ !== 1'b0) begin
            fails++;
            $display("FAIL midreset_own: slrd=%b required 0", slrd_);
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if ({slrd_, sloe_, gnt, busy} !== {1'b1, 1'b1, 3'b000, 1'b0}) begin
            fails++;
            $display("FAIL midreset_after: slrd=%b sloe=%b gnt=%b busy=%b required 1 1 000 0", slrd_, sloe_, gnt, busy);
        end
        reset = 1'b0; req = 3'b100; slrd_req_n = 3'b111; sloe_req_n = 3'b111;
        tick();
        tests_run++;
        if (gnt !== 3'b100) begin
            fails++;
            $display("FAIL midreset_regrant: gnt=%b required 100", gnt);
        end
        req = 3'b000;
        repeat (6) tick();
    endtask

    task automatic test_non_owner_done();
        do_reset();
        req = 3'b001;
        tick();
        tick();
        done = 3'b110;
        tick();
        done = 3'b000;
        tests_run++;
        if ({gnt, busy} !== {3'b001, 1'b1}) begin
            fails++;
            $display("FAIL nonowner_done: gnt=%b busy=%b required 001 1", gnt, busy);
        end
        tick();
        tests_run++;
        if (gnt !== 3'b001) begin
            fails++;
            $display("FAIL nonowner_hold: gnt=%b required 001", gnt);
        end
        req = 3'b000;
        repeat (4) tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 3'b001;
        tick();
        tick();
        done = 3'b001;
        tick();
        done = 3'b000;
        repeat (3) tick();
        tests_run++;
        if (gnt !== 3'b001) begin
            fails++;
            $display("FAIL b2b_same: gnt=%b required 001", gnt);
        end
        req = 3'b101;
        tick();
        done = 3'b001;
        tick();
        done = 3'b000;
        repeat (3) tick();
        tests_run++;
        if (gnt !== 3'b100) begin
            fails++;
            $display("FAIL b2b_rotate: gnt=%b required 100", gnt);
        end
        req = 3'b000;
        repeat (5) tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        req = 3'b010;
        tick();
        tick();
`ifdef SLAVEFIFO_ARB_WATCHDOG_EN
        repeat (15) tick();
        tests_run++;
        if ({gnt, timeout} !== {3'b010, 1'b0}) begin
            fails++;
            $display("FAIL wd_own16: gnt=%b timeout=%b required 010 0", gnt, timeout);
        end
        tick();
        tests_run++;
        if ({gnt, timeout} !== {3'b000, 1'b1}) begin
            fails++;
            $display("FAIL wd_fire: gnt=%b timeout=%b required 000 1", gnt, timeout);
        end
        tick();
        tests_run++;
        if (timeout !== 1'b0) begin
            fails++;
            $display("FAIL wd_pulse: timeout=%b required 0", timeout);
        end
        tick();
        tick();
        tests_run++;
        if (gnt !== 3'b010) begin
            fails++;
            $display("FAIL wd_regrant: gnt=%b required 010", gnt);
        end
`else
        begin
            int to_seen;
            to_seen = 0;
            for (int c = 0; c < 1000; c++) begin
                tick();
                if (timeout !== 1'b0) to_seen++;
            end
            tests_run++;
            if (to_seen != 0) begin
                fails++;
                $display("FAIL wd_off_timeout: %0d cycles with timeout high, required 0", to_seen);
            end
            tests_run++;
            if ({gnt, busy} !== {3'b010, 1'b1}) begin
                fails++;
                $display("FAIL wd_off_hold: gnt=%b busy=%b required 010 1", gnt, busy);
            end
        end
`endif
        req = 3'b000;
        repeat (5) tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_turnaround();
        test_mid_reset();
        test_non_owner_done();
        test_back_to_back();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
